multi_corr_pktizer: RTL and testbench

- Multi-channel successor to the single-pair correlator.
- Counts X, Y, intersection (X&Y) and symmetric difference (X^Y) over rectangular sample windows for N_PAIRS independent input pairs.
- Each count is normalised to window length, snapshotted at window end and serialised as a byte packet on a valid/ready stream.
- Windows that end while a packet is still draining are dropped; the drop is counted and flagged in the next header.

---
 rtl/multi_corr_pktizer.sv | 207 ++++++++++++++++++++
 tb/tb_multi_corr_pktizer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_corr_pktizer.sv
// multi_corr_pktizer
//   For each of N_PAIRS (x,y) bit pairs, counts X, Y, X&Y and X^Y over
//   rectangular windows of 2^wle samples. Each count is normalised to the
//   window length and snapshotted when the window ends. The snapshot is then
//   sent as a byte packet: one header byte, then 4 report bytes per pair.
//   A window that ends while the previous packet is still being sent is
//   dropped. The drop is counted and flagged in the next header.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_cg                 clock gate: low freezes the window and count logic
//   i_sampleStrobe       take one sample this cycle (qualified by i_cg)
//   i_windowLengthExp    window length exponent, clamped to TIME_W
//   i_x, i_y             one bit per pair
//   o_data/o_valid       packet byte stream to the sink
//   i_ready              sink accepts the byte
//   o_busy               serializer not idle
//   o_nDropped           saturating count of dropped windows

// Per-pair counters and normalisation.
// o_report is combinational. It includes the sample being taken this cycle,
// so the top level can capture it on the wrap cycle.
module multi_corr_pktizer_lane #(
    parameter int TIME_W = 16,
    parameter int WLE_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_samp,
    input  logic              i_wrap,
    input  logic              i_x,
    input  logic              i_y,
    input  logic [WLE_W-1:0]  i_wle,
    output logic [3:0][7:0]   o_report
);
    localparam int CW = TIME_W + 1;
    localparam logic [WLE_W-1:0] TW_L = WLE_W'(TIME_W);

    logic [3:0]          w_hit;
    logic [3:0][CW-1:0]  r_cnt;
    logic [3:0][CW-1:0]  w_next;
    logic [WLE_W-1:0]    w_sh;

    // Report order: X, Y, intersection, symmetric difference.
    assign w_hit = {i_x ^ i_y, i_x & i_y, i_y, i_x};
    assign w_sh  = TW_L - i_wle;

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        logic [CW-1:0] w_s;
        logic          w_sat;

        assign w_next[k] = r_cnt[k] + CW'(w_hit[k]);

        // A count of 2^wle or more is a full window.
        // This also covers a window shortened by a wle change, where the
        // count can exceed the length of the new window.
        assign w_sat = (w_next[k] >> i_wle) != '0;
        assign w_s   = w_next[k] << w_sh;
        assign o_report[k] = w_sat ? 8'hFF : 8'(w_s >> (TIME_W - 8));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_samp)
            r_cnt <= i_wrap ? '0 : w_next;
    end
endmodule

module multi_corr_pktizer #(
    parameter int N_PAIRS = 4,
    parameter int TIME_W  = 16,
    parameter int WLE_W   = $clog2(TIME_W + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cg,
    input  logic               i_sampleStrobe,
    input  logic [WLE_W-1:0]   i_windowLengthExp,
    input  logic [N_PAIRS-1:0] i_x,
    input  logic [N_PAIRS-1:0] i_y,
    output logic [7:0]         o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic [7:0]         o_nDropped
);
    localparam int NB    = 4 * N_PAIRS;
    localparam int IDX_W = $clog2(NB);
    localparam logic [WLE_W-1:0] TW_L     = WLE_W'(TIME_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]                r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [TIME_W-1:0]         r_t;
    logic [6:0]                r_winNum;
    logic [7:0]                r_nDropped;
    logic                      r_dropPending;
    logic [7:0]                r_hdr;
    logic [NB-1:0][7:0]        r_snap;

    logic [WLE_W-1:0]          w_wle;
    logic [TIME_W-1:0]         w_mask;
    logic                      w_samp;
    logic                      w_wrap;
    logic                      w_hs;
    logic                      w_last;
    logic                      w_free;
    logic [N_PAIRS-1:0][3:0][7:0] w_rep;

    assign w_wle  = (i_windowLengthExp > TW_L) ? TW_L : i_windowLengthExp;
    // Low wle bits set. wle==0 gives an empty mask, so every sample wraps.
    assign w_mask = ~({TIME_W{1'b1}} << w_wle);
    assign w_samp = i_sampleStrobe & i_cg;
    // The wle in force right now is used, so a change lands on the next
    // boundary that is aligned for the new length.
    assign w_wrap = w_samp & ((r_t & w_mask) == w_mask);

    assign w_hs   = o_valid & i_ready;
    assign w_last = (r_idx == IDX_LAST);
    assign w_free = (r_state == S_IDLE) | ((r_state == S_DATA) & w_hs & w_last);

    for (genvar p = 0; p < N_PAIRS; p++) begin : g_lane
        multi_corr_pktizer_lane #(
            .TIME_W (TIME_W),
            .WLE_W  (WLE_W)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_samp   (w_samp),
            .i_wrap   (w_wrap),
            .i_x      (i_x[p]),
            .i_y      (i_y[p]),
            .i_wle    (w_wle),
            .o_report (w_rep[p])
        );
    end

    // Window timing, snapshot capture and drop accounting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t           <= '0;
            r_winNum      <= '0;
            r_nDropped    <= '0;
            r_dropPending <= 1'b0;
            r_hdr         <= '0;
            r_snap        <= '0;
        end else if (w_samp) begin
            r_t <= w_wrap ? '0 : r_t + TIME_W'(1);
            if (w_wrap) begin
                // The window number advances on dropped windows too,
                // so the sink can see the gaps.
                r_winNum <= r_winNum + 7'd1;
                if (w_free) begin
                    r_snap        <= w_rep;
                    r_hdr         <= {r_dropPending, r_winNum};
                    r_dropPending <= 1'b0;
                end else begin
                    if (r_nDropped != 8'hFF)
                        r_nDropped <= r_nDropped + 8'd1;
                    r_dropPending <= 1'b1;
                end
            end
        end
    end

    // Serializer. A wrap together with the last-byte handshake goes straight
    // to HDR, so o_valid stays high across back-to-back packets.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_wrap) r_state <= S_HDR;
                S_HDR: if (w_hs) begin
                    r_state <= S_DATA;
                    r_idx   <= '0;
                end
                S_DATA: if (w_hs) begin
                    if (w_last)
                        r_state <= w_wrap ? S_HDR : S_IDLE;
                    else
                        r_idx <= r_idx + IDX_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_data = 8'h00;
        case (r_state)
            S_HDR:   o_data = r_hdr;
            S_DATA:  o_data = r_snap[r_idx];
            default: o_data = 8'h00;
        endcase
    end

    assign o_valid    = (r_state != S_IDLE);
    assign o_busy     = (r_state != S_IDLE);
    assign o_nDropped = r_nDropped;
endmodule

// File: tb/tb_multi_corr_pktizer.sv
// Bench for multi_corr_pktizer with N_PAIRS=2 and TIME_W=16.
// A reference model runs alongside the DUT. It keeps a window of counts and
// a byte queue that stands for the packet being sent. Table vectors and
// hand-built sequences add constant expectations on top of the model.
module tb_multi_corr_pktizer;
    localparam int NP = 2;
    localparam int TW = 16;
    localparam int WW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cg = 1'b1;
    logic          strobe = 1'b0;
    logic [WW-1:0] wle = '0;
    logic [NP-1:0] x = '0;
    logic [NP-1:0] y = '0;
    logic          ready = 1'b1;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          o_busy;
    logic [7:0]    o_nDropped;

    multi_corr_pktizer #(.N_PAIRS(NP), .TIME_W(TW), .WLE_W(WW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cg              (cg),
        .i_sampleStrobe    (strobe),
        .i_windowLengthExp (wle),
        .i_x               (x),
        .i_y               (y),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .i_ready           (ready),
        .o_busy            (o_busy),
        .o_nDropped        (o_nDropped)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;

    // Reference model state
    int m_t, m_win, m_ndrop;
    bit m_dp;
    int m_cnt[NP][4];
    int mq[$];
    int cap[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int norm(int c, int w);
        if (c >= (1 << w)) return 255;
        return ((c << (TW - w)) >> (TW - 8)) & 255;
    endfunction

    task automatic model_reset();
        m_t = 0; m_win = 0; m_ndrop = 0; m_dp = 0;
        foreach (m_cnt[p, k]) m_cnt[p][k] = 0;
        mq.delete();
    endtask

    task automatic model_step();
        bit hs, fr, wr;
        int w;
        hs = (mq.size() > 0) && ready;
        fr = (mq.size() == 0) || (mq.size() == 1 && hs);
        if (hs) void'(mq.pop_front());
        if (!(strobe && cg)) return;
        w = (int'(wle) > TW) ? TW : int'(wle);
        for (int p = 0; p < NP; p++) begin
            m_cnt[p][0] += int'(x[p]);
            m_cnt[p][1] += int'(y[p]);
            m_cnt[p][2] += int'(x[p] & y[p]);
            m_cnt[p][3] += int'(x[p] ^ y[p]);
        end
        wr = (m_t % (1 << w)) == ((1 << w) - 1);
        if (wr) begin
            if (fr) begin
                mq.push_back((int'(m_dp) << 7) | m_win);
                for (int p = 0; p < NP; p++)
                    for (int k = 0; k < 4; k++) mq.push_back(norm(m_cnt[p][k], w));
                m_dp = 0;
            end else begin
                if (m_ndrop < 255) m_ndrop++;
                m_dp = 1;
            end
            m_win = (m_win + 1) % 128;
            foreach (m_cnt[p, k]) m_cnt[p][k] = 0;
            m_t = 0;
        end else begin
            m_t = (m_t + 1) % (1 << TW);
        end
    endtask

    // One clock: update the model on the edge, then compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("valid", o_valid, mq.size() > 0);
        chk("busy", o_busy, mq.size() > 0);
        chk("ndrop", o_nDropped, m_ndrop);
        if (mq.size() > 0) chk("data", o_data, mq[0]);
        if (o_valid && ready) cap.push_back(o_data);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ndrop", o_nDropped, 0);
        model_reset();
        rst_n = 1'b1;
        cap.delete();
    endtask

    task automatic collect(int n);
        int b = 0;
        ready = 1'b1;
        while (cap.size() < n && b < 40) begin
            tick();
            b++;
        end
        chk("pkt_len", cap.size(), n);
    endtask

    typedef struct {
        int         wle;
        int         k;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[14];
    logic [7:0] t1e[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Each row is one window with pair0 x high for the first k samples
        // and y low. The row gives the expected X and Symdiff report.
        tbl = '{
            '{4, 16, 8'hFF}, '{4, 8, 8'h80}, '{4, 0, 8'h00}, '{4, 1, 8'h10},
            '{2, 2, 8'h80},  '{2, 3, 8'hC0}, '{2, 4, 8'hFF}, '{0, 1, 8'hFF},
            '{0, 0, 8'h00},  '{8, 1, 8'h01}, '{8, 255, 8'hFF}, '{10, 3, 8'h00},
            '{10, 512, 8'h80}, '{3, 5, 8'hA0}};
        t1e = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h00};

        model_reset();
        do_reset();

        // Table-driven normalisation vectors
        foreach (tbl[r]) begin
            do_reset();
            wle = WW'(tbl[r].wle); ready = 1'b1; cg = 1'b1; y = '0;
            for (int i = 0; i < (1 << tbl[r].wle); i++) begin
                x = {1'b0, (i < tbl[r].k)};
                strobe = 1'b1;
                tick();
            end
            strobe = 1'b0; x = '0;
            collect(9);
            if (cap.size() >= 9) begin
                chk($sformatf("tbl%0d_X", r), cap[1], tbl[r].exp);
                chk($sformatf("tbl%0d_I", r), cap[3], 0);
                chk($sformatf("tbl%0d_S", r), cap[4], tbl[r].exp);
            end
        end

        // Basic packet, wle=4, with latency check
        do_reset();
        wle = 5'd4; ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x = {(i % 2 == 0), 1'b1};
            y = {(i % 2 == 0), 1'b0};
            strobe = 1'b1;
            tick();
            if (i < 15) chk("t1_early_valid", o_valid, 0);
        end
        chk("t1_valid", o_valid, 1);
        strobe = 1'b0; x = '0; y = '0;
        collect(9);
        if (cap.size() >= 9)
            for (int j = 0; j < 9; j++) chk($sformatf("t1_byte%0d", j), cap[j], t1e[j]);

        // wle=3: alternate windows dropped, header flags the drop
        do_reset();
        wle = 5'd3; ready = 1'b1; strobe = 1'b1;
        for (int i = 0; i < 32; i++) begin
            x = NP'($urandom); y = NP'($urandom);
            tick();
            if (i == 23) chk("t3_hdr", o_data, 8'h82);
        end
        chk("t3_ndrop", o_nDropped, 8'd2);

        // Last byte accepted in the same cycle as the wrap: no drop
        do_reset();
        wle = 5'd4; ready = 1'b1; strobe = 1'b1; x = '0; y = '0;
        for (int i = 0; i < 16; i++) tick();
        for (int k = 1; k <= 16; k++) begin
            ready = (k >= 3 && k <= 9) ? 1'b0 : 1'b1;
            tick();
        end
        chk("t3b_valid", o_valid, 1);
        chk("t3b_hdr", o_data, 8'h01);
        chk("t3b_ndrop", o_nDropped, 8'd0);

        // wle 4->2 at t=5: wrap at t=7
        do_reset();
        wle = 5'd4; ready = 1'b1; strobe = 1'b1; x = 2'b01; y = '0;
        for (int i = 0; i < 5; i++) tick();
        wle = 5'd2;
        tick(); chk("t4_nowrap6", o_valid, 0);
        tick(); chk("t4_nowrap7", o_valid, 0);
        tick(); chk("t4_wrap", o_valid, 1);
        strobe = 1'b0;
        collect(9);
        if (cap.size() >= 9) begin
            chk("t4_X", cap[1], 8'hFF);
            chk("t4_Y", cap[2], 8'h00);
        end

        // Clock gate freezes the window while the packet drains
        do_reset();
        wle = 5'd4; ready = 1'b1; strobe = 1'b1; cg = 1'b1; x = 2'b01; y = '0;
        for (int i = 0; i < 16; i++) tick();
        x = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        cg = 1'b0; x = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_drained", o_valid, 0);
        cg = 1'b1; x = 2'b00;
        for (int i = 0; i < 12; i++) tick();
        chk("t5_nowrap", o_valid, 0);
        cap.delete();
        tick();
        chk("t5_wrap", o_valid, 1);
        strobe = 1'b0;
        collect(9);
        if (cap.size() >= 9) chk("t5_X", cap[1], 8'h00);

        // wle=0 with sink stalled: nDropped saturates
        do_reset();
        wle = 5'd0; ready = 1'b0; strobe = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = NP'($urandom); y = NP'($urandom);
            tick();
        end
        chk("t2_hold_valid", o_valid, 1);
        chk("t2_hold_hdr", o_data, 8'h00);
        chk("t2_sat", o_nDropped, 8'hFF);
        strobe = 1'b0; ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("t2_drained", o_valid, 0);
        strobe = 1'b1;
        tick();
        chk("t2_hdr", o_data, 8'hAC);

        // Reset in the middle of a packet, at DATA idx 3
        strobe = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        wle = 5'd4; strobe = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t6_busy_before", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", o_valid, 0);
        chk("t6_data", o_data, 8'h00);
        chk("t6_busy", o_busy, 0);
        chk("t6_ndrop", o_nDropped, 8'h00);
        model_reset();
        #2 rst_n = 1'b1;
        cap.delete();
        for (int i = 0; i < 16; i++) tick();
        chk("t6_hdr_valid", o_valid, 1);
        chk("t6_hdr", o_data, 8'h00);

        // Randomized run against the model
        do_reset();
        wle = 5'd3;
        for (int i = 0; i < 4000; i++) begin
            strobe = ($urandom % 4) != 0;
            cg     = ($urandom % 8) != 0;
            ready  = ($urandom % 4) != 0;
            x = NP'($urandom); y = NP'($urandom);
            if ($urandom % 200 == 0)
                wle = ($urandom % 10 == 0) ? 5'd31 : WW'($urandom_range(0, 5));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
